// File: rtl/m_cpu_pkg.sv
// Shared CPU datapath types: data/register-address widths and the fetch request record.
// Consumed by operand_fetch (optional OPERAND_FETCH_BYPASS_EN) and its register file.
package m_cpu_pkg;

  localparam int DATA_W = 16;
  localparam int NREG   = 16;
  localparam int REG_AW = $clog2(NREG);

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t rs1;
    reg_addr_t rs2;
    reg_addr_t rd;
    logic      use_c;
    logic      cin;
  } fetch_req_t;

  // True when an address names an implemented register.
  function automatic logic addr_in_range(input int unsigned addr, input int unsigned nreg);
    return addr < nreg;
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register array: two combinational read ports, one synchronous write port, r0 = 0.
// With OPERAND_FETCH_BYPASS_EN defined, a same-cycle write is forwarded to a matching read port.
module regfile_2r1w
  import m_cpu_pkg::*;
#(
  parameter int N    = DATA_W,
  parameter int NREG = m_cpu_pkg::NREG,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  output logic [N-1:0]  rs1_data,
  output logic [N-1:0]  rs2_data,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [N-1:0]  wb_data
);

  logic [N-1:0] mem_q [NREG];
  logic [N-1:0] mem_d [NREG];

  // Only entries 1..NREG-1 are writable; unimplemented addresses match no entry.
  always_comb begin
    mem_d = mem_q;
    for (int i = 1; i < NREG; i++) begin
      if (wb_en && wb_addr == AW'(i)) begin
        mem_d[i] = wb_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    for (int i = 1; i < NREG; i++) begin
      if (rs1_addr == AW'(i)) rs1_data = mem_q[i];
      if (rs2_addr == AW'(i)) rs2_data = mem_q[i];
    end
`ifdef OPERAND_FETCH_BYPASS_EN
    // Forward the in-flight write so a dependent read sees it with no extra cycle.
    if (wb_en && rs1_addr == wb_addr && rs1_addr != '0 &&
        addr_in_range(32'(rs1_addr), NREG)) begin
      rs1_data = wb_data;
    end
    if (wb_en && rs2_addr == wb_addr && rs2_addr != '0 &&
        addr_in_range(32'(rs2_addr), NREG)) begin
      rs2_data = wb_data;
    end
`endif
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: register file, carry flag, and a one-entry valid/ready output slot.
// Optional OPERAND_FETCH_BYPASS_EN forwards same-cycle write-back data and carry to the read.
module operand_fetch
  import m_cpu_pkg::*;
#(
  parameter int N    = DATA_W,
  parameter int NREG = m_cpu_pkg::NREG,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_rs1,
  input  logic [AW-1:0] in_rs2,
  input  logic [AW-1:0] in_rd,
  input  logic          in_use_c,
  input  logic          in_cin,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  rs1_reg,
  output logic [N-1:0]  rs2_reg,
  output logic          cin,
  output logic [AW-1:0] out_rd,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [N-1:0]  wb_data,
  input  logic          wb_cout
);

  logic [N-1:0]  rf_rs1_data;
  logic [N-1:0]  rf_rs2_data;
  logic          accept;
  logic          carry_sel;

  logic          carry_q, carry_d;
  logic          out_valid_q, out_valid_d;
  logic [N-1:0]  rs1_q, rs1_d;
  logic [N-1:0]  rs2_q, rs2_d;
  logic          cin_q, cin_d;
  logic [AW-1:0] rd_q, rd_d;

  regfile_2r1w #(
    .N    (N),
    .NREG (NREG)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (in_rs1),
    .rs2_addr (in_rs2),
    .rs1_data (rf_rs1_data),
    .rs2_data (rf_rs2_data),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data)
  );

  // A slot being drained this cycle can be refilled in the same cycle.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    carry_sel = carry_q;
`ifdef OPERAND_FETCH_BYPASS_EN
    if (wb_en) carry_sel = wb_cout;
`endif

    out_valid_d = out_valid_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    cin_d       = cin_q;
    rd_d        = rd_q;
    if (accept) begin
      out_valid_d = 1'b1;
      rs1_d       = rf_rs1_data;
      rs2_d       = rf_rs2_data;
      cin_d       = in_use_c ? carry_sel : in_cin;
      rd_d        = in_rd;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    carry_d = wb_en ? wb_cout : carry_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      cin_q       <= 1'b0;
      rd_q        <= '0;
    end else begin
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      cin_q       <= cin_d;
      rd_q        <= rd_d;
    end
  end

  assign out_valid = out_valid_q;
  assign rs1_reg   = rs1_q;
  assign rs2_reg   = rs2_q;
  assign cin       = cin_q;
  assign out_rd    = rd_q;

endmodule
